aemb2_thread_ctl: RTL and testbench

//  Pipeline/thread controller for the AEMB2 core. Generates the global pipeline enable (dena) and

---
 rtl/aemb2_pkg.sv | 8 +
 rtl/aemb2_sync2.sv | 12 +
 rtl/aemb2_thread_ctl.sv | 77 +++++++
 tb/tb_aemb2_thread_ctl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/aemb2_pkg.sv
// aemb2_pkg: shared break codes, controller state encoding and MSR bit positions.
package aemb2_pkg;
    localparam logic [1:0] BRK_NONE = 2'b00;
    localparam logic [1:0] BRK_INT  = 2'b01;
    typedef enum logic [1:0] {ST_RST = 2'b00, ST_RUN = 2'b01, ST_STALL = 2'b10} state_t;
    localparam int MSR_IE  = 1;
    localparam int MSR_BIP = 3;
endpackage

// File: rtl/aemb2_sync2.sv
// aemb2_sync2: two-flop synchroniser, asynchronous active-low reset to 0.
module aemb2_sync2 (
    input  logic gclk,
    input  logic grst,
    input  logic d,
    output logic q
);
    logic m;
    always_ff @(posedge gclk or negedge grst)
        if (!grst) {q, m} <= 2'b00;
        else       {q, m} <= {m, d};
endmodule

// File: rtl/aemb2_thread_ctl.sv
// aemb2_thread_ctl: pipeline enable, thread phase and interrupt break injection for AEMB2.
// AEMB2_INT_EDGE_EN selects edge-triggered interrupt pending; default is level-sensitive.
module aemb2_thread_ctl
    import aemb2_pkg::*;
#(
    parameter int AEMB_HTX     = 1,
    parameter int AEMB_RST_CYC = 3,
    parameter int AEMB_HOLD    = 2
) (
    input  logic       gclk,
    input  logic       grst,
    input  logic       iwb_stl_i,
    input  logic       dwb_stb_i,
    input  logic       dwb_ack_i,
    input  logic       sys_int_i,
    input  logic [7:0] msr_ex_i,
    output logic       dena,
    output logic       gpha,
    output logic [1:0] brk_o,
    output logic       int_pnd_o
);
    localparam logic [3:0] RST_LAST = 4'(AEMB_RST_CYC - 1);
    localparam logic [3:0] HOLD_LD  = 4'(AEMB_HOLD);
    localparam logic       HTX      = (AEMB_HTX != 0);

    state_t     state;
    logic [3:0] rst_cnt;
    logic [3:0] hold_cnt;
    logic       int_s;
    logic       int_pnd;
    logic       stall;
    logic       inj;
    logic       unused_msr;

    aemb2_sync2 u_sync (.gclk(gclk), .grst(grst), .d(sys_int_i), .q(int_s));

    assign unused_msr = ^{msr_ex_i[7:4], msr_ex_i[2], msr_ex_i[0]};
    assign stall      = iwb_stl_i | (dwb_stb_i & ~dwb_ack_i);
    assign dena       = (state != ST_RST) & ~stall;
    assign inj        = dena & int_pnd & msr_ex_i[MSR_IE] & ~msr_ex_i[MSR_BIP] & ~gpha & (hold_cnt == 4'd0);
    assign int_pnd_o  = int_pnd;

`ifdef AEMB2_INT_EDGE_EN
    logic int_d;
    // a new edge beats a same-cycle injection so no request is dropped
    always_ff @(posedge gclk or negedge grst)
        if (!grst) begin
            int_d   <= 1'b0;
            int_pnd <= 1'b0;
        end else begin
            int_d   <= int_s;
            int_pnd <= (int_s & ~int_d) | (int_pnd & ~inj);
        end
`else
    assign int_pnd = int_s;
`endif

    always_ff @(posedge gclk or negedge grst)
        if (!grst) begin
            state    <= ST_RST;
            rst_cnt  <= 4'd0;
            gpha     <= 1'b0;
            brk_o    <= BRK_NONE;
            hold_cnt <= 4'd0;
        end else begin
            if (state == ST_RST) begin
                rst_cnt <= rst_cnt + 4'd1;
                if (rst_cnt == RST_LAST) state <= ST_RUN;
            end else begin
                state <= stall ? ST_STALL : ST_RUN;
            end
            if (dena) gpha <= HTX & ~gpha;
            brk_o    <= inj ? BRK_INT : dena ? BRK_NONE : brk_o;
            // hold window masks the cycle before the integer unit drops IE
            hold_cnt <= inj ? HOLD_LD : (dena && hold_cnt != 4'd0) ? hold_cnt - 4'd1 : hold_cnt;
        end
endmodule

// File: tb/tb_aemb2_thread_ctl.sv
// tb_aemb2_thread_ctl: directed plus randomized bench against a behavioural model.
module tb_aemb2_thread_ctl;
    localparam int RST_CYC = 3;
    localparam int HOLD    = 2;
    localparam int HTX     = 1;

    logic       gclk = 1'b0;
    logic       grst = 1'b0;
    logic       iwb_stl_i = 1'b0;
    logic       dwb_stb_i = 1'b0;
    logic       dwb_ack_i = 1'b0;
    logic       sys_int_i = 1'b0;
    logic [7:0] msr_ex_i = 8'h00;
    logic       dena;
    logic       gpha;
    logic [1:0] brk_o;
    logic       int_pnd_o;

    int checks = 0;
    int errors = 0;

    // behavioural model: flush countdown, phase bit, break flag, dena count since injection
    int flush;
    int since;
    bit m_gpha, m_brk, s1, s2, s3, m_pnd_e;

    always #5 gclk = ~gclk;

    aemb2_thread_ctl #(.AEMB_HTX(HTX), .AEMB_RST_CYC(RST_CYC), .AEMB_HOLD(HOLD)) dut (
        .gclk(gclk), .grst(grst), .iwb_stl_i(iwb_stl_i), .dwb_stb_i(dwb_stb_i),
        .dwb_ack_i(dwb_ack_i), .sys_int_i(sys_int_i), .msr_ex_i(msr_ex_i),
        .dena(dena), .gpha(gpha), .brk_o(brk_o), .int_pnd_o(int_pnd_o)
    );

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_dena();
        return flush == 0 && !(iwb_stl_i || (dwb_stb_i && !dwb_ack_i));
    endfunction

    function automatic bit m_pnd();
`ifdef AEMB2_INT_EDGE_EN
        return m_pnd_e;
`else
        return s2;
`endif
    endfunction

    task automatic model_reset();
        flush = RST_CYC; since = HOLD;
        m_gpha = 0; m_brk = 0; s1 = 0; s2 = 0; s3 = 0; m_pnd_e = 0;
    endtask

    task automatic model_step();
        bit d, inj;
        d   = m_dena();
        inj = d && m_pnd() && msr_ex_i[1] && !msr_ex_i[3] && !m_gpha && since >= HOLD;
        if (flush > 0) flush--;
        if (d && HTX != 0) m_gpha = !m_gpha;
        m_brk = inj ? 1'b1 : d ? 1'b0 : m_brk;
        if (inj) since = 0;
        else if (d && since < HOLD) since++;
        m_pnd_e = (s2 && !s3) || (m_pnd_e && !inj);
        s3 = s2; s2 = s1; s1 = sys_int_i;
    endtask

    task automatic tick();
        @(posedge gclk);
        if (grst) model_step();
        #2;
    endtask

    always @(negedge gclk)
        if (grst) begin
            chk("dena", {1'b0, dena}, {1'b0, m_dena()});
            chk("gpha", {1'b0, gpha}, {1'b0, m_gpha});
            chk("brk_o", brk_o, {1'b0, m_brk});
            chk("int_pnd_o", {1'b0, int_pnd_o}, {1'b0, m_pnd()});
        end

    initial begin
        int dut_cnt, mdl_cnt;
        bit seen;
        model_reset();
        tick(); tick();
        chk("rst_dena", {1'b0, dena}, 2'd0);
        chk("rst_gpha", {1'b0, gpha}, 2'd0);
        chk("rst_brk", brk_o, 2'd0);
        grst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge gclk);
            chk("flush_dena", {1'b0, dena}, (i >= 3) ? 2'd1 : 2'd0);
            chk("flush_gpha", {1'b0, gpha}, (i >= 4) ? 2'((i - 3) % 2) : 2'd0);
            tick();
        end
        dwb_stb_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge gclk);
            chk("dwait_dena", {1'b0, dena}, 2'd0);
            chk("dwait_gpha", {1'b0, gpha}, 2'd1);
            tick();
        end
        dwb_ack_i = 1'b1;
        @(negedge gclk);
        chk("ack_dena", {1'b0, dena}, 2'd1);
        chk("ack_gpha", {1'b0, gpha}, 2'd1);
        tick();
        dwb_stb_i = 1'b0; dwb_ack_i = 1'b0;
        msr_ex_i = 8'h02; sys_int_i = 1'b1;
        dut_cnt = 0; mdl_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge gclk);
            if (brk_o == 2'b01) dut_cnt++;
            if (m_brk) mdl_cnt++;
            tick();
        end
        sys_int_i = 1'b0;
        chk("int_count", 2'(dut_cnt), 2'(mdl_cnt));
`ifdef AEMB2_INT_EDGE_EN
        chk("int_once", 2'(dut_cnt), 2'd1);
`else
        chk("int_reinject", {1'b0, dut_cnt >= 3}, 2'd1);
`endif
        repeat (4) tick();
        msr_ex_i = 8'h00; sys_int_i = 1'b1;
        repeat (4) tick();
        @(negedge gclk);
        chk("ie0_pnd", {1'b0, int_pnd_o}, 2'd1);
        chk("ie0_brk", brk_o, 2'd0);
        tick();
        msr_ex_i = 8'h02; seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge gclk);
            seen = (brk_o == 2'b01);
            tick();
        end
        chk("ie1_inject", {1'b0, seen}, 2'd1);
        msr_ex_i = 8'h00;
        repeat (4) tick();
        iwb_stl_i = 1'b1;
        tick(); tick();
        grst = 1'b0;
        #1;
        chk("arst_dena", {1'b0, dena}, 2'd0);
        chk("arst_gpha", {1'b0, gpha}, 2'd0);
        chk("arst_brk", brk_o, 2'd0);
        chk("arst_pnd", {1'b0, int_pnd_o}, 2'd0);
        model_reset();
        tick(); tick();
        iwb_stl_i = 1'b0; sys_int_i = 1'b0; grst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge gclk);
            chk("reflush_dena", {1'b0, dena}, (i >= 3) ? 2'd1 : 2'd0);
            tick();
        end
        for (int i = 0; i < 3000; i++) begin
            iwb_stl_i = ($urandom_range(0, 4) == 0);
            dwb_stb_i = ($urandom_range(0, 2) == 0);
            dwb_ack_i = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 7) == 0) sys_int_i = ~sys_int_i;
            msr_ex_i = 8'($urandom_range(0, 255));
            msr_ex_i[1] = ($urandom_range(0, 3) != 0);
            msr_ex_i[3] = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 399) == 0) begin
                grst = 1'b0;
                model_reset();
                tick(); tick();
                grst = 1'b1;
            end
            tick();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
